dma_voice_req_arbiter: RTL and testbench
========================================

Name: dma_voice_req_arbiter

Overview:
Round-robin arbiter that shares one DMA read channel between NUM_REQ voice DMA requesters (voice-info fetch FSMs, voice-stream fetch FSMs).
- Accepts one request at a time and presents its address and length to the DMA master.
- Holds the grant until the DMA reports done.
- Routes returned data, valid and done strobes back to the granted requester only.
- Sits between the per-voice request FSMs and the AXI DMA master.

Parameters:
NUM_REQ, 4, number of requesters (2..16).
C_M_AXI_ADDR_WIDTH, 32, address width.
C_M_AXI_DATA_WIDTH, 32, data width.
TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles (used only with the optional feature).

Ports:
clk  in  1  clock.
reset_n  in  1  asynchronous, active-low reset.
req_valid  in  NUM_REQ  per-requester request; held high until req_ack.
req_addr  in  NUM_REQ*C_M_AXI_ADDR_WIDTH  packed request addresses; slice i belongs to requester i.
req_len  in  NUM_REQ*8  packed burst lengths, 8 bits each.
req_ack  out  NUM_REQ  one-cycle accept pulse to the granted requester.
rsp_data  out  C_M_AXI_DATA_WIDTH  returned data, broadcast to all requesters.
rsp_data_valid  out  NUM_REQ  data strobe, granted requester only.
rsp_done  out  NUM_REQ  done strobe, granted requester only.
dma_req  out  1  one-cycle request pulse to the DMA master.
dma_addr  out  C_M_AXI_ADDR_WIDTH  latched address, stable from dma_req until done.
dma_req_len  out  8  latched length, stable from dma_req until done.
dma_input_data  in  C_M_AXI_DATA_WIDTH  DMA read data.
dma_input_data_valid  in  1  DMA data strobe.
dma_done  in  1  DMA transfer-complete pulse.
busy  out  1  high whenever the state is not IDLE.
grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.

Behaviour:
- Reset values: all outputs 0. State = IDLE. Internal last_grant = NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, ISSUE, WAIT_DONE.
- IDLE:
  - If any req_valid bit is set, select the first set bit searching upward from last_grant+1 with wrap-around.
  - Register grant_id, dma_addr and dma_req_len from the selected slice, then go to ISSUE.
  - If no bit is set, stay in IDLE.
- ISSUE (exactly one cycle):
  - dma_req = 1 and req_ack[grant_id] = 1, both registered.
  - Latency: req_valid high at rising edge k produces dma_req high during cycle k+1.
  - Go to WAIT_DONE.
- WAIT_DONE:
  - Combinational, zero-latency routing: rsp_data = dma_input_data, rsp_data_valid[grant_id] = dma_input_data_valid, rsp_done[grant_id] = dma_done.
  - All other requesters' strobes stay 0.
  - On dma_done: last_grant <= grant_id and go to IDLE. The earliest next dma_req is 2 cycles after done.
- A requester can therefore be granted at most once per full round while other requests are pending (no starvation).
- dma_input_data_valid and dma_done in the same cycle: forward both, then return to IDLE.
- dma_input_data_valid or dma_done while in IDLE or ISSUE: ignored, never forwarded.
- req_valid dropped after selection but before ack: the transfer proceeds with the latched addr/len.
- req_valid changes during WAIT_DONE: do not affect the transfer in progress.
- req_len = 0: passed through unchanged; the arbiter waits for dma_done regardless of beat count.
- rsp_data outside WAIT_DONE is 0.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs 0. Late DMA strobes after reset are ignored per the IDLE rule.

Optional Feature:
Macro DMA_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_DONE and increments every WAIT_DONE cycle without dma_done.
  - When the count reaches TIMEOUT_CYCLES: pulse rsp_done[grant_id], set sticky output timeout_err (1 bit, extra port, reset 0, cleared only by reset), last_grant <= grant_id, go to IDLE.
- Not defined: no counter, no timeout_err port; WAIT_DONE waits indefinitely for dma_done.

Test Plan:
- Single request: req_valid[0]=1, addr 0x1000, len 16; DMA model returns 16 beats then done. Expect dma_req one cycle after, dma_addr=0x1000, dma_req_len=16, req_ack[0] pulse, 16 rsp_data_valid[0] pulses, rsp_done[0]; other strobes 0.
- All four requesting continuously: grant order 0,1,2,3,0. Each dma_addr matches its slice (0x100*i). busy stays 1 except the single IDLE cycle between transfers.
- Wrap and skip: after a grant to 3, req_valid=0b0101. Expect grant 0, then 2.
- Spurious strobes: dma_input_data_valid/dma_done pulses in IDLE produce no rsp_* activity. A simultaneous final valid+done in WAIT_DONE forwards both.
- Reset mid-transfer: reset_n low during beat 5 of 64. Expect all outputs 0. After release, a request from 2 with last_grant reset gives grant_id=0 if 0 requests, otherwise 2.
- With DMA_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=32: DMA never sends done. Expect rsp_done pulse 32 cycles into WAIT_DONE, timeout_err=1, and the next request granted normally.

Source files
------------

// File: rtl/dma_voice_req_arbiter.sv
// dma_voice_req_arbiter
// Round-robin arbiter sharing one DMA read channel between NUM_REQ voice
// fetch requesters. One request is accepted at a time, its address/length
// are latched and presented to the DMA master, and returned data/valid/done
// strobes are routed back to the granted requester until the DMA signals done.
//
// Optional feature: define DMA_ARB_TIMEOUT_EN to add a WAIT_DONE watchdog of
// TIMEOUT_CYCLES cycles and the sticky timeout_err output.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req_valid/addr/len      per-requester request (packed, slice i = requester i)
//   req_ack                 one-cycle accept pulse to the granted requester
//   rsp_data                returned data (broadcast, 0 outside WAIT_DONE)
//   rsp_data_valid/rsp_done strobes routed to the granted requester only
//   dma_req/addr/req_len    request to the DMA master (registered)
//   dma_input_data[_valid]  DMA read data and strobe
//   dma_done                DMA transfer-complete pulse
//   busy                    state is not IDLE
//   timeout_err             sticky watchdog flag (DMA_ARB_TIMEOUT_EN only)
//   grant_id                current or last granted requester

module dma_voice_req_arbiter #(
   parameter int unsigned NUM_REQ            = 4,
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic [NUM_REQ-1:0]                    req_valid,
   input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*8-1:0]                  req_len,
   output logic [NUM_REQ-1:0]                    req_ack,
   output logic [C_M_AXI_DATA_WIDTH-1:0]         rsp_data,
   output logic [NUM_REQ-1:0]                    rsp_data_valid,
   output logic [NUM_REQ-1:0]                    rsp_done,
   output logic                                  dma_req,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]         dma_addr,
   output logic [7:0]                            dma_req_len,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]         dma_input_data,
   input  logic                                  dma_input_data_valid,
   input  logic                                  dma_done,
   output logic                                  busy,
`ifdef DMA_ARB_TIMEOUT_EN
   output logic                                  timeout_err,
`endif
   output logic [$clog2(NUM_REQ)-1:0]            grant_id
);

   localparam int unsigned ID_W = $clog2(NUM_REQ);
   localparam int unsigned AW   = C_M_AXI_ADDR_WIDTH;
   localparam int unsigned LW   = 8;

   // Elaboration guard on the parameter ranges the design supports
   if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES == 0) begin : g_bad_param
      $error("dma_voice_req_arbiter: unsupported parameter value");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_DONE
   } state_t;

   state_t            state_q, state_nxt;
   logic [ID_W-1:0]   last_grant_q, last_grant_nxt;
   logic [ID_W-1:0]   grant_nxt;
   logic [AW-1:0]     addr_nxt;
   logic [LW-1:0]     len_nxt;
   logic              dma_req_nxt;
   logic [NUM_REQ-1:0] ack_nxt;

   logic [AW-1:0]     addr_arr [NUM_REQ];
   logic [LW-1:0]     len_arr  [NUM_REQ];
   logic              sel_found;
   logic [ID_W-1:0]   sel_id;
   logic [NUM_REQ-1:0] sel_oh;
   logic [NUM_REQ-1:0] grant_oh;
   logic              timeout_hit_c;

   // Unpack the flat request buses into per-requester slices
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         addr_arr[i] = req_addr[i*AW +: AW];
         len_arr[i]  = req_len[i*LW +: LW];
      end
   end

   // Round-robin pick: first set bit searching upward from last_grant+1
   always_comb begin
      int unsigned idx;
      sel_found = 1'b0;
      sel_id    = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = (32'(last_grant_q) + k) % NUM_REQ;
         if (!sel_found && req_valid[ID_W'(idx)]) begin
            sel_found = 1'b1;
            sel_id    = ID_W'(idx);
         end
      end
   end

   // One-hot decodes of the candidate and the current grant
   always_comb begin
      sel_oh           = '0;
      sel_oh[sel_id]   = 1'b1;
      grant_oh         = '0;
      grant_oh[grant_id] = 1'b1;
   end

`ifdef DMA_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] tmo_cnt_q;

   assign timeout_hit_c = (state_q == S_WAIT_DONE) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES));

   // Watchdog: cleared entering WAIT_DONE, counts cycles without dma_done
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmo_cnt_q   <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state_q == S_ISSUE) begin
            tmo_cnt_q <= '0;
         end else if (state_q == S_WAIT_DONE && !dma_done && !timeout_hit_c) begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
         end
         if (timeout_hit_c && !dma_done) begin
            timeout_err <= 1'b1;
         end
      end
   end
`else
   assign timeout_hit_c = 1'b0;
`endif

   // Next-state and next registered-output values
   always_comb begin
      state_nxt      = state_q;
      last_grant_nxt = last_grant_q;
      grant_nxt      = grant_id;
      addr_nxt       = dma_addr;
      len_nxt        = dma_req_len;
      dma_req_nxt    = 1'b0;
      ack_nxt        = '0;
      unique case (state_q)
         S_IDLE: begin
            if (sel_found) begin
               grant_nxt   = sel_id;
               addr_nxt    = addr_arr[sel_id];
               len_nxt     = len_arr[sel_id];
               dma_req_nxt = 1'b1;
               ack_nxt     = sel_oh;
               state_nxt   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_nxt = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (dma_done || timeout_hit_c) begin
               last_grant_nxt = grant_id;
               state_nxt      = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         last_grant_q <= ID_W'(NUM_REQ - 1);
         grant_id     <= '0;
         dma_addr     <= '0;
         dma_req_len  <= '0;
         dma_req      <= 1'b0;
         req_ack      <= '0;
         busy         <= 1'b0;
      end else begin
         state_q      <= state_nxt;
         last_grant_q <= last_grant_nxt;
         grant_id     <= grant_nxt;
         dma_addr     <= addr_nxt;
         dma_req_len  <= len_nxt;
         dma_req      <= dma_req_nxt;
         req_ack      <= ack_nxt;
         busy         <= (state_nxt != S_IDLE);
      end
   end

   // Zero-latency response routing, only while a transfer is in flight
   always_comb begin
      rsp_data       = '0;
      rsp_data_valid = '0;
      rsp_done       = '0;
      if (state_q == S_WAIT_DONE) begin
         rsp_data = dma_input_data;
         if (dma_input_data_valid) begin
            rsp_data_valid = grant_oh;
         end
         if (dma_done || timeout_hit_c) begin
            rsp_done = grant_oh;
         end
      end
   end

endmodule

// File: tb/tb_dma_voice_req_arbiter.sv
// Directed self-checking bench for dma_voice_req_arbiter (NUM_REQ = 4).
module tb_dma_voice_req_arbiter;

   logic          clk;
   logic          reset_n;
   logic [3:0]    req_valid;
   logic [127:0]  req_addr;
   logic [31:0]   req_len;
   logic [3:0]    req_ack;
   logic [31:0]   rsp_data;
   logic [3:0]    rsp_data_valid;
   logic [3:0]    rsp_done;
   logic          dma_req;
   logic [31:0]   dma_addr;
   logic [7:0]    dma_req_len;
   logic [31:0]   dma_input_data;
   logic          dma_input_data_valid;
   logic          dma_done;
   logic          busy;
   logic [1:0]    grant_id;
`ifdef DMA_ARB_TIMEOUT_EN
   logic          timeout_err;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   dma_voice_req_arbiter #(
      .NUM_REQ(4), .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(32)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ack(req_ack),
      .rsp_data(rsp_data), .rsp_data_valid(rsp_data_valid), .rsp_done(rsp_done),
      .dma_req(dma_req), .dma_addr(dma_addr), .dma_req_len(dma_req_len),
      .dma_input_data(dma_input_data), .dma_input_data_valid(dma_input_data_valid),
      .dma_done(dma_done), .busy(busy),
`ifdef DMA_ARB_TIMEOUT_EN
      .timeout_err(timeout_err),
`endif
      .grant_id(grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_req"},  64'(dma_req), 64'(0));
      chk({tag, "_ack"},  64'(req_ack), 64'(0));
      chk({tag, "_dv"},   64'(rsp_data_valid), 64'(0));
      chk({tag, "_done"}, 64'(rsp_done), 64'(0));
      chk({tag, "_data"}, 64'(rsp_data), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int exp_g [6] = '{0, 1, 2, 3, 0, 2};
      int g;

      reset_n = 1'b0; req_valid = '0; req_addr = '0; req_len = '0;
      dma_input_data = '0; dma_input_data_valid = 1'b0; dma_done = 1'b0;
      repeat (3) step();

      // Reset state
      @(negedge clk);
      chk_quiet("rst");
      chk("rst_grant", 64'(grant_id), 64'(0));
      chk("rst_addr",  64'(dma_addr), 64'(0));
      chk("rst_len",   64'(dma_req_len), 64'(0));
      reset_n = 1'b1;
      step();

      // Single request from 0: addr 0x1000, len 16, 16 beats then done
      req_valid = 4'b0001;
      req_addr[31:0] = 32'h0000_1000;
      req_len[7:0]   = 8'd16;
      step();
      @(negedge clk);
      chk("t1_dma_req", 64'(dma_req), 64'(1));
      chk("t1_ack",     64'(req_ack), 64'(4'b0001));
      chk("t1_addr",    64'(dma_addr), 64'(32'h1000));
      chk("t1_len",     64'(dma_req_len), 64'(16));
      chk("t1_grant",   64'(grant_id), 64'(0));
      chk("t1_busy",    64'(busy), 64'(1));
      chk("t1_iss_dv",  64'(rsp_data_valid), 64'(0));
      step();
      req_valid = 4'b0000;
      for (int b = 0; b < 16; b++) begin
         dma_input_data = 32'hA000 + 32'(b);
         dma_input_data_valid = 1'b1;
         @(negedge clk);
         chk("t1_beat_dv",   64'(rsp_data_valid), 64'(4'b0001));
         chk("t1_beat_data", 64'(rsp_data), 64'(32'hA000 + 32'(b)));
         chk("t1_beat_done", 64'(rsp_done), 64'(0));
         chk("t1_beat_req",  64'(dma_req), 64'(0));
         step();
      end
      dma_input_data_valid = 1'b0;
      dma_done = 1'b1;
      @(negedge clk);
      chk("t1_done",      64'(rsp_done), 64'(4'b0001));
      chk("t1_done_dv",   64'(rsp_data_valid), 64'(0));
      chk("t1_done_addr", 64'(dma_addr), 64'(32'h1000));
      chk("t1_done_busy", 64'(busy), 64'(1));
      step();
      dma_done = 1'b0;
      @(negedge clk);
      chk_quiet("t1_idle");

      // All four requesting: 0,1,2,3,0 then wrap/skip with 0b0101 -> 0,2
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_addr[i*32 +: 32] = 32'h100 * 32'(i);
         req_len[i*8 +: 8]    = 8'(4 + i);
      end
      req_valid = 4'b1111;
      step();
      for (int t = 0; t < 6; t++) begin
         g = exp_g[t];
         @(negedge clk);
         chk("t2_dma_req", 64'(dma_req), 64'(1));
         chk("t2_grant",   64'(grant_id), 64'(g));
         chk("t2_addr",    64'(dma_addr), 64'(32'h100 * 32'(g)));
         chk("t2_len",     64'(dma_req_len), 64'(4 + g));
         chk("t2_ack",     64'(req_ack), 64'(64'd1 << g));
         chk("t2_busy_iss", 64'(busy), 64'(1));
         step();
         if (t == 3) req_valid = 4'b0101;
         if (t == 5) req_valid = 4'b0000;
         dma_done = 1'b1;
         @(negedge clk);
         chk("t2_done",      64'(rsp_done), 64'(64'd1 << g));
         chk("t2_busy_wait", 64'(busy), 64'(1));
         step();
         dma_done = 1'b0;
         @(negedge clk);
         chk("t2_busy_idle", 64'(busy), 64'(0));
         step();
      end
      @(negedge clk);
      chk_quiet("t2_end");

      // Spurious strobes in IDLE are not forwarded
      step();
      dma_input_data = 32'hDEAD_BEEF;
      dma_input_data_valid = 1'b1;
      dma_done = 1'b1;
      @(negedge clk);
      chk_quiet("t3_spur");
      step();
      dma_input_data_valid = 1'b0;
      dma_done = 1'b0;
      @(negedge clk);
      chk("t3_spur_busy", 64'(busy), 64'(0));

      // Request from 1 (last grant 2), len 0, dropped before ack; strobes in ISSUE ignored
      req_valid = 4'b0010;
      req_addr[63:32] = 32'h4444_0000;
      req_len[15:8]   = 8'd0;
      step();
      req_valid = 4'b0000;
      dma_input_data = 32'h1234_5678;
      dma_input_data_valid = 1'b1;
      dma_done = 1'b1;
      @(negedge clk);
      chk("t3_grant",    64'(grant_id), 64'(1));
      chk("t3_len0",     64'(dma_req_len), 64'(0));
      chk("t3_addr",     64'(dma_addr), 64'(32'h4444_0000));
      chk("t3_iss_done", 64'(rsp_done), 64'(0));
      chk("t3_iss_dv",   64'(rsp_data_valid), 64'(0));
      chk("t3_iss_data", 64'(rsp_data), 64'(0));
      step();
      @(negedge clk);
      chk("t3_both_dv",   64'(rsp_data_valid), 64'(4'b0010));
      chk("t3_both_done", 64'(rsp_done), 64'(4'b0010));
      chk("t3_both_data", 64'(rsp_data), 64'(32'h1234_5678));
      step();
      dma_input_data_valid = 1'b0;
      dma_done = 1'b0;
      @(negedge clk);
      chk_quiet("t3_idle");

      // Reset during beat 5 of a 64-beat transfer from 3
      req_valid = 4'b1000;
      req_len[31:24] = 8'd64;
      step();
      @(negedge clk);
      chk("t4_grant", 64'(grant_id), 64'(3));
      chk("t4_len",   64'(dma_req_len), 64'(64));
      step();
      req_valid = 4'b0000;
      for (int b = 0; b < 5; b++) begin
         dma_input_data = 32'hB00 + 32'(b);
         dma_input_data_valid = 1'b1;
         @(negedge clk);
         chk("t4_beat_dv", 64'(rsp_data_valid), 64'(4'b1000));
         step();
      end
      dma_input_data = 32'hB05;
      #2;
      reset_n = 1'b0;
      dma_done = 1'b1;
      #1;
      chk_quiet("t4_rst");
      chk("t4_rst_grant", 64'(grant_id), 64'(0));
      chk("t4_rst_addr",  64'(dma_addr), 64'(0));
      chk("t4_rst_len",   64'(dma_req_len), 64'(0));
      @(negedge clk);
      reset_n = 1'b1;
      step();
      @(negedge clk);
      chk_quiet("t4_late");
      step();
      dma_input_data_valid = 1'b0;
      dma_done = 1'b0;
      req_valid = 4'b0100;
      step();
      @(negedge clk);
      chk("t4_grant2", 64'(grant_id), 64'(2));
      chk("t4_ack2",   64'(req_ack), 64'(4'b0100));
      step();
      req_valid = 4'b0000;
      dma_done = 1'b1;
      step();
      dma_done = 1'b0;
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      req_valid = 4'b0101;
      step();
      @(negedge clk);
      chk("t4_grant0", 64'(grant_id), 64'(0));
      step();
      req_valid = 4'b0000;
      dma_done = 1'b1;
      step();
      dma_done = 1'b0;

`ifdef DMA_ARB_TIMEOUT_EN
      // DMA never completes: watchdog fires 32 cycles into WAIT_DONE
      req_valid = 4'b0001;
      step();
      step();
      req_valid = 4'b0000;
      for (int j = 1; j <= 32; j++) begin
         @(negedge clk);
         chk("t5_no_done", 64'(rsp_done), 64'(0));
         step();
      end
      @(negedge clk);
      chk("t5_tmo_done", 64'(rsp_done), 64'(4'b0001));
      chk("t5_err_pre",  64'(timeout_err), 64'(0));
      step();
      @(negedge clk);
      chk("t5_err",  64'(timeout_err), 64'(1));
      chk("t5_busy", 64'(busy), 64'(0));
      req_valid = 4'b0010;
      step();
      @(negedge clk);
      chk("t5_next_grant", 64'(grant_id), 64'(1));
      chk("t5_next_req",   64'(dma_req), 64'(1));
      step();
      req_valid = 4'b0000;
      dma_done = 1'b1;
      step();
      dma_done = 1'b0;
      @(negedge clk);
      chk("t5_err_sticky", 64'(timeout_err), 64'(1));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
